// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP driving datapath strobes.
// Define MCTRL_MULDIV_EN to accept M-extension ops on OP and hold EXEC until alu_done.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                zero,
    input  logic                alu_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          mem_to_reg,
    output logic                auipc,
    output logic                halted,
    output logic                retire,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       op_q, op_d;
    logic [2:0]       f3_q, f3_d;
    logic             f75_q, f75_d;
    logic             f725_q, f725_d;

    logic is_load, is_store, is_opimm, is_op, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic op_ok, legal, taken, timeout_hit;
    logic [3:0] aop4;

    assign is_load   = (op_q == 7'b0000011);
    assign is_store  = (op_q == 7'b0100011);
    assign is_opimm  = (op_q == 7'b0010011);
    assign is_op     = (op_q == 7'b0110011);
    assign is_branch = (op_q == 7'b1100011);
    assign is_jal    = (op_q == 7'b1101111);
    assign is_jalr   = (op_q == 7'b1100111);
    assign is_lui    = (op_q == 7'b0110111);
    assign is_auipc  = (op_q == 7'b0010111);

`ifdef MCTRL_MULDIV_EN
    logic is_muldiv;
    assign is_muldiv = is_op & f725_q;
    // funct7 with both bit 30 and bit 25 set is neither a base nor an M op.
    assign op_ok     = ~(f725_q & f75_q);
`else
    logic unused_alu_done;
    assign unused_alu_done = alu_done;
    assign op_ok           = ~f725_q;
`endif

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:26], instr[24:15], instr[11:7]};

    assign legal = is_load | is_store | is_opimm | (is_op & op_ok) | is_branch
                 | is_jal | is_jalr | is_lui | is_auipc;
    assign taken       = f3_q[0] ? ~zero : zero;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign alu_op      = ALU_OP_W'(aop4);
    assign state_dbg   = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            f75_q   <= 1'b0;
            f725_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            f75_q   <= f75_d;
            f725_q  <= f725_d;
        end
    end

    // Memory handshake: mem_req is raised in FETCH/MEM and held until the cycle mem_ready=1,
    // which completes the access; it only drops early on timeout (TRAP) or reset.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        op_d       = op_q;
        f3_d       = f3_q;
        f75_d      = f75_q;
        f725_d     = f725_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        alu_src_b  = 1'b0;
        aop4       = 4'b0000;
        mem_to_reg = 2'b00;
        auipc      = 1'b0;
        halted     = 1'b0;
        retire     = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    op_d     = instr[6:0];
                    f3_d     = instr[14:12];
                    f75_d    = instr[30];
                    f725_d   = instr[25];
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                alu_src_b = ~(is_op | is_branch);
                auipc     = is_auipc;
                if (is_op)
                    aop4 = {f75_q, f3_q};
                else if (is_opimm)
                    aop4 = {f75_q & (f3_q == 3'b101), f3_q};
                else if (is_branch)
                    aop4 = 4'b0100;
                if (is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = taken ? 2'b10 : 2'b00;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_load | is_store) begin
                    state_d = S_MEM;
`ifdef MCTRL_MULDIV_EN
                end else if (is_muldiv) begin
                    aop4 = {1'b1, f3_q};
                    if (alu_done)
                        state_d = S_WB;
`endif
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                mem_to_reg = is_load ? 2'b11 : (is_jal | is_jalr) ? 2'b10 : is_lui ? 2'b01 : 2'b00;
                pc_src     = is_jal ? 2'b10 : is_jalr ? 2'b01 : 2'b00;
                state_d    = S_FETCH;
            end
            S_TRAP: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors are queued by the
// driver and checked by an independent negedge monitor. Honors MCTRL_MULDIV_EN for the mul case.
module tb_multicycle_control;

    localparam int W = 18;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        alu_done = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic        alu_src_b, auipc, halted, retire;
    logic [1:0]  pc_src, mem_to_reg;
    logic [3:0]  alu_op;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4), .ALU_OP_W(4)) dut (
        .clk(clk), .rstn(rstn), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .alu_done(alu_done), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .auipc(auipc),
        .halted(halted), .retire(retire), .state_dbg(state_dbg)
    );

    logic [W-1:0] act;
    assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, alu_src_b,
                  alu_op, mem_to_reg, auipc, halted, retire};

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_pass = 0;
    int           n_total = 0;

    function automatic logic [W-1:0] ov(input logic req, we, io, irw, pcw, input logic [1:0] pcs,
                                        input logic rw, srcb, input logic [3:0] aop,
                                        input logic [1:0] m2r, input logic aui, hlt, ret);
        return {req, we, io, irw, pcw, pcs, rw, srcb, aop, m2r, aui, hlt, ret};
    endfunction

    localparam logic [W-1:0] E0 = '0;
    localparam logic [W-1:0] E_TRAP = 18'h00002;

    function automatic logic [W-1:0] f_fetch(input logic rdy);
        return ov(1, 0, 0, rdy, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] f_exec(input logic [3:0] aop, input logic srcb, aui);
        return ov(0, 0, 0, 0, 0, 2'b00, 0, srcb, aop, 2'b00, aui, 0, 0);
    endfunction
    function automatic logic [W-1:0] f_br(input logic tk);
        return ov(0, 0, 0, 0, 1, tk ? 2'b10 : 2'b00, 0, 0, 4'b0100, 2'b00, 0, 0, 1);
    endfunction
    function automatic logic [W-1:0] f_mem(input logic we, fin);
        return ov(1, we, 1, 0, fin, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0, fin);
    endfunction
    function automatic logic [W-1:0] f_wb(input logic [1:0] m2r, pcs);
        return ov(0, 0, 0, 0, 1, pcs, 1, 0, 4'h0, m2r, 0, 0, 1);
    endfunction

    // Drive one cycle of inputs (called at posedge+1) and queue the expected outputs.
    task automatic step(input logic rdy, z, dn, input logic [31:0] ins, input logic [W-1:0] e,
                        input string nm);
        mem_ready = rdy;
        zero      = z;
        alu_done  = dn;
        instr     = ins;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rstn = 1'b0;
        step(0, 0, 0, 32'h0, E0, {nm, "_rst"});
        rstn = 1'b1;
        step(0, 0, 0, 32'h0, E0, {nm, "_idle"});
    endtask

    task automatic fetch_decode(input logic [31:0] ins, input string nm);
        step(1, 0, 0, ins, f_fetch(1), {nm, "_fetch"});
        step(0, 0, 0, 32'h0, E0, {nm, "_decode"});
    endtask

    task automatic run_simple(input logic [31:0] ins, input logic [3:0] aop, input logic srcb, aui,
                              input logic [1:0] m2r, pcs, input string nm);
        fetch_decode(ins, nm);
        step(0, 0, 0, 32'h0, f_exec(aop, srcb, aui), {nm, "_exec"});
        step(0, 0, 0, 32'h0, f_wb(m2r, pcs), {nm, "_wb"});
    endtask

    task automatic run_branch(input logic [31:0] ins, input logic z, tk, input string nm);
        fetch_decode(ins, nm);
        step(0, z, 0, 32'h0, f_br(tk), {nm, "_exec"});
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        string        nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (act === e)
                n_pass++;
            else
                $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 32'h0, E0, "rst_hold");
        rstn = 1'b1;
        step(0, 0, 0, 32'h0, E0, "idle");
        step(0, 0, 0, 32'h0, f_fetch(0), "fetch_req");
        step(0, 0, 0, 32'h0, f_fetch(0), "fetch_req2");
        rstn = 1'b0;
        step(1, 0, 0, 32'h00500093, E0, "rst_mid_fetch");
        rstn = 1'b1;
        step(0, 0, 0, 32'h0, E0, "idle_after_rst");

        step(0, 0, 0, 32'h0, f_fetch(0), "addi_fetch_wait");
        run_simple(32'h00500093, 4'b0000, 1, 0, 2'b00, 2'b00, "addi");

        run_branch(32'h00208463, 1, 1, "beq_z1");
        run_branch(32'h00208463, 0, 0, "beq_z0");
        run_branch(32'h00209463, 1, 0, "bne_z1");
        run_branch(32'h00209463, 0, 1, "bne_z0");

        fetch_decode(32'h0000A183, "lw");
        step(0, 0, 0, 32'h0, f_exec(4'b0000, 1, 0), "lw_exec");
        repeat (3) step(0, 0, 0, 32'h0, f_mem(0, 0), "lw_mem_wait");
        step(1, 0, 0, 32'h0, f_mem(0, 0), "lw_mem_rdy");
        step(0, 0, 0, 32'h0, f_wb(2'b11, 2'b00), "lw_wb");

        fetch_decode(32'h0030A223, "sw");
        step(0, 0, 0, 32'h0, f_exec(4'b0000, 1, 0), "sw_exec");
        repeat (3) step(0, 0, 0, 32'h0, f_mem(1, 0), "sw_mem_wait");
        step(1, 0, 0, 32'h0, f_mem(1, 1), "sw_mem_rdy");

        run_simple(32'h402081B3, 4'b1000, 0, 0, 2'b00, 2'b00, "sub");
        run_simple(32'h0020C1B3, 4'b0100, 0, 0, 2'b00, 2'b00, "xor");
        run_simple(32'h4030D093, 4'b1101, 1, 0, 2'b00, 2'b00, "srai");
        run_simple(32'hC0000093, 4'b0000, 1, 0, 2'b00, 2'b00, "addi_neg");
        run_simple(32'h008000EF, 4'b0000, 1, 0, 2'b10, 2'b10, "jal");
        run_simple(32'h00008067, 4'b0000, 1, 0, 2'b10, 2'b01, "jalr");
        run_simple(32'h123452B7, 4'b0000, 1, 0, 2'b01, 2'b00, "lui");
        run_simple(32'h00000297, 4'b0000, 1, 1, 2'b00, 2'b00, "auipc");

        fetch_decode(32'h022081B3, "mul");
`ifdef MCTRL_MULDIV_EN
        repeat (4) step(0, 0, 0, 32'h0, f_exec(4'b1000, 0, 0), "mul_exec_hold");
        step(0, 0, 1, 32'h0, f_exec(4'b1000, 0, 0), "mul_exec_done");
        step(0, 0, 0, 32'h0, f_wb(2'b00, 2'b00), "mul_wb");
`else
        step(0, 0, 1, 32'h0, E_TRAP, "mul_trap");
        step(1, 0, 1, 32'h0, E_TRAP, "mul_trap_hold");
`endif
        do_reset("after_mul");

        fetch_decode(32'h0000007F, "illegal");
        step(1, 0, 0, 32'h0, E_TRAP, "illegal_trap");
        step(1, 0, 0, 32'h0, E_TRAP, "illegal_trap_hold");
        do_reset("after_illegal");

        repeat (4) step(0, 0, 0, 32'h0, f_fetch(0), "fetch_timeout_wait");
        repeat (3) step(1, 0, 0, 32'h00500093, E_TRAP, "fetch_timeout_trap");
        do_reset("after_fetch_timeout");

        fetch_decode(32'h0000A183, "lw_to");
        step(0, 0, 0, 32'h0, f_exec(4'b0000, 1, 0), "lw_to_exec");
        repeat (4) step(0, 0, 0, 32'h0, f_mem(0, 0), "lw_to_mem_wait");
        repeat (2) step(1, 0, 0, 32'h0, E_TRAP, "mem_timeout_trap");

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
